pipelined_cla_addsub: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor built from GROUP-bit carry-lookahead groups.
- Successor to the fixed 20-bit combinational add/sub used in the ODE step datapath.
- Generalised width and pipeline depth, with valid/ready flow control so results stream into the step/accumulate path at full clock rate.
- Carry is registered between pipeline stages; operand and result bits are skewed so each transaction emerges intact.

---
 rtl/pipelined_cla_addsub.sv | 157 +++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined GROUP-bit carry-lookahead add/sub with valid/ready flow control
// Optional sum clamp on signed overflow: define PIPELINED_CLA_ADDSUB_SATURATE_EN.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 20,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             v
);

  localparam int NG  = WIDTH / GROUP;
  localparam int GPS = (NG + STAGES - 1) / STAGES;
  localparam int L   = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cm;
  } res_t;

  // Evaluates groups lo..hi-1 with full lookahead inside each group; cm is the carry into the MSB.
  function automatic res_t cla_span(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] s_prev, input logic c0,
                                    input logic cm0, input int lo, input int hi);
    res_t             r;
    logic [GROUP-1:0] gv;
    logic [GROUP-1:0] pv;
    logic [GROUP:0]   cy;
    logic             term;
    r.s  = s_prev;
    r.c  = c0;
    r.cm = cm0;
    gv   = '0;
    pv   = '0;
    cy   = '0;
    term = 1'b0;
    for (int g = 0; g < NG; g++) begin
      if (g >= lo && g < hi) begin
        gv    = a[g*GROUP +: GROUP] & b[g*GROUP +: GROUP];
        pv    = a[g*GROUP +: GROUP] ^ b[g*GROUP +: GROUP];
        cy    = '0;
        cy[0] = r.c;
        for (int i = 1; i <= GROUP; i++) begin
          term = r.c;
          for (int k = 0; k < i; k++) term = term & pv[k];
          cy[i] = term;
          for (int j = 0; j < i; j++) begin
            term = gv[j];
            for (int k = j + 1; k < i; k++) term = term & pv[k];
            cy[i] = cy[i] | term;
          end
        end
        r.s[g*GROUP +: GROUP] = pv ^ cy[GROUP-1:0];
        if (g == NG - 1) r.cm = cy[GROUP-1];
        r.c = cy[GROUP];
      end
    end
    return r;
  endfunction

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q, cm_q, c_d, cm_d;
  logic [STAGES-1:0] valid_q, ready, up_valid;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * GPS;
    localparam int HI = ((s + 1) * GPS > NG) ? NG : (s + 1) * GPS;
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in, cm_in;
    res_t             r;

    if (s == 0) begin : g_first
      assign a_in        = in0;
      assign b_in        = sub ? ~in1 : in1;
      assign c_in        = sub | cin;
      assign s_in        = '0;
      assign cm_in       = 1'b0;
      assign up_valid[s] = in_valid;
    end else begin : g_next
      assign a_in        = a_q[s-1];
      assign b_in        = b_q[s-1];
      assign c_in        = c_q[s-1];
      assign s_in        = s_q[s-1];
      assign cm_in       = cm_q[s-1];
      assign up_valid[s] = valid_q[s-1];
    end

    assign r       = cla_span(a_in, b_in, s_in, c_in, cm_in, LO, HI);
    assign a_d[s]  = a_in;
    assign b_d[s]  = b_in;
    assign c_d[s]  = r.c;
    assign cm_d[s] = r.cm;

    if (s == L) begin : g_last
      assign ready[s] = !valid_q[s] | out_ready;
`ifdef PIPELINED_CLA_ADDSUB_SATURATE_EN
      // Overflow direction follows the sign of in0: both operands share it when v=1.
      assign s_d[s] = (r.cm ^ r.c) ? (a_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}})
                                   : r.s;
`else
      assign s_d[s] = r.s;
`endif
    end else begin : g_mid
      assign ready[s] = !valid_q[s] | ready[s+1];
      assign s_d[s]   = r.s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      cm_q    <= '0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (ready[s]) valid_q[s] <= up_valid[s];
        if (ready[s] && up_valid[s]) begin
          a_q[s]  <= a_d[s];
          b_q[s]  <= b_d[s];
          s_q[s]  <= s_d[s];
          c_q[s]  <= c_d[s];
          cm_q[s] <= cm_d[s];
        end
      end
    end
  end

  assign in_ready  = !rst & ready[0];
  assign out_valid = valid_q[L];
  assign sum       = s_q[L];
  assign cout      = c_q[L];
  assign v         = cm_q[L] ^ c_q[L];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - directed bench for pipelined_cla_addsub (WIDTH=20, GROUP=4, STAGES=2)
module tb_pipelined_cla_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sub = 1'b0;
  logic [19:0] in0 = '0;
  logic [19:0] in1 = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [19:0] sum;
  logic        cout;
  logic        v;

  int errors = 0;
  int checks = 0;

`ifdef PIPELINED_CLA_ADDSUB_SATURATE_EN
  localparam logic [19:0] EXP_POS_OVF = 20'h7FFFF;
  localparam logic [19:0] EXP_NEG_OVF = 20'h80000;
`else
  localparam logic [19:0] EXP_POS_OVF = 20'h80000;
  localparam logic [19:0] EXP_NEG_OVF = 20'h7FFFF;
`endif

  typedef struct {
    logic [19:0] a;
    logic [19:0] b;
    logic        s;
    logic        c;
    logic [19:0] es;
    logic        ec;
    logic        ev;
    string       nm;
  } vec_t;

  pipelined_cla_addsub #(.WIDTH(20), .GROUP(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .in0(in0), .in1(in1), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .v(v)
  );

  always #5 clk = ~clk;

  // Offers one transaction from just after a negedge and returns what emerges and when.
  task automatic drive_one(input logic [19:0] a, input logic [19:0] b, input logic s, input logic c,
                           output logic acc, output int lat, output logic [19:0] rs,
                           output logic rc, output logic rv);
    in0 = a; in1 = b; sub = s; cin = c; in_valid = 1'b1;
    #1 acc = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; rs = '0; rc = 1'b0; rv = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i; rs = sum; rc = cout; rv = v;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in0 = 20'h12345; in1 = 20'h11111; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 20'h0) begin errors++; $display("FAIL reset_sum: got %h want 00000", sum); end
    checks++; if ({cout, v} !== 2'b00) begin errors++; $display("FAIL reset_cout_v: got %b want 00", {cout, v}); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    logic acc, rc, rv; int lat; logic [19:0] rs;
    drive_one(20'h7FFFF, 20'h00001, 1'b0, 1'b0, acc, lat, rs, rc, rv);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL add_ovf_accept: got %b want 1", acc); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_ovf_latency: got %0d want 2", lat); end
    checks++; if (rs !== EXP_POS_OVF) begin errors++; $display("FAIL add_ovf_sum: got %h want %h", rs, EXP_POS_OVF); end
    checks++; if (rc !== 1'b0) begin errors++; $display("FAIL add_ovf_cout: got %b want 0", rc); end
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL add_ovf_v: got %b want 1", rv); end
  endtask

  task automatic test_arithmetic();
    vec_t tbl[7];
    logic acc, rc, rv; int lat; logic [19:0] rs;
    tbl[0] = '{20'h00005, 20'h00007, 1'b1, 1'b0, 20'hFFFFE, 1'b0, 1'b0, "sub_5_7"};
    tbl[1] = '{20'h00005, 20'h00007, 1'b1, 1'b1, 20'hFFFFE, 1'b0, 1'b0, "sub_5_7_cin"};
    tbl[2] = '{20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, "wrap_b1"};
    tbl[3] = '{20'hFFFFF, 20'h00000, 1'b0, 1'b1, 20'h00000, 1'b1, 1'b0, "wrap_cin"};
    tbl[4] = '{20'h0FFFF, 20'h00001, 1'b0, 1'b0, 20'h10000, 1'b0, 1'b0, "group_chain"};
    tbl[5] = '{20'h12345, 20'h6789A, 1'b0, 1'b0, 20'h79BDF, 1'b0, 1'b0, "mixed_add"};
    tbl[6] = '{20'h00000, 20'h00000, 1'b1, 1'b0, 20'h00000, 1'b1, 1'b0, "sub_zero"};
    foreach (tbl[i]) begin
      drive_one(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, acc, lat, rs, rc, rv);
      checks++; if (lat !== 2) begin errors++; $display("FAIL %s latency: got %0d want 2", tbl[i].nm, lat); end
      checks++; if (rs !== tbl[i].es) begin errors++; $display("FAIL %s sum: got %h want %h", tbl[i].nm, rs, tbl[i].es); end
      checks++; if ({rc, rv} !== {tbl[i].ec, tbl[i].ev}) begin
        errors++; $display("FAIL %s cout_v: got %b want %b", tbl[i].nm, {rc, rv}, {tbl[i].ec, tbl[i].ev});
      end
    end
  endtask

  task automatic test_saturate();
    logic acc, rc, rv; int lat; logic [19:0] rs;
    drive_one(20'h80000, 20'h00001, 1'b1, 1'b0, acc, lat, rs, rc, rv);
    checks++; if (rs !== EXP_NEG_OVF) begin errors++; $display("FAIL sat_neg_sum: got %h want %h", rs, EXP_NEG_OVF); end
    checks++; if ({rc, rv} !== 2'b11) begin errors++; $display("FAIL sat_neg_cout_v: got %b want 11", {rc, rv}); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] a[4], b[4], e[4];
    logic        s[4], c[4];
    a = '{20'h0FFFF, 20'h00003, 20'h12345, 20'hFFFFF};
    b = '{20'h00001, 20'h00005, 20'h6789A, 20'h00000};
    s = '{1'b0, 1'b1, 1'b0, 1'b0};
    c = '{1'b0, 1'b0, 1'b0, 1'b1};
    e = '{20'h10000, 20'hFFFFE, 20'h79BDF, 20'h00000};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = (cyc < 4);
      if (cyc < 4) begin in0 = a[cyc]; in1 = b[cyc]; sub = s[cyc]; cin = c[cyc]; end
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc%0d: got %b want 1", cyc, in_ready); end
      checks++; if (out_valid !== (cyc >= 2 && cyc < 6)) begin
        errors++; $display("FAIL b2b_out_valid cyc%0d: got %b want %b", cyc, out_valid, (cyc >= 2 && cyc < 6));
      end
      if (cyc >= 2 && cyc < 6) begin
        checks++; if (sum !== e[cyc-2]) begin errors++; $display("FAIL b2b_sum cyc%0d: got %h want %h", cyc, sum, e[cyc-2]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int          sent = 0, got = 0, occ = 0;
    logic [19:0] prev_sum = '0;
    logic        stalled = 1'b0, saw_drop = 1'b0, acc, oxf;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 5);
      in_valid = (sent < 5); in0 = 20'(sent); in1 = 20'h00001; sub = 1'b0; cin = 1'b0;
      #1;
      checks++; if (in_ready !== !(occ == 2 && !out_ready)) begin
        errors++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, in_ready, !(occ == 2 && !out_ready));
      end
      if (in_ready === 1'b0) saw_drop = 1'b1;
      if (stalled) begin
        checks++; if (sum !== prev_sum) begin errors++; $display("FAIL bp_hold cyc%0d: got %h want %h", cyc, sum, prev_sum); end
      end
      acc = in_valid && in_ready;
      oxf = out_valid && out_ready;
      if (oxf) begin
        checks++; if (sum !== 20'(got + 1)) begin errors++; $display("FAIL bp_order: got %h want %h", sum, 20'(got + 1)); end
        got++;
      end
      stalled = out_valid && !out_ready;
      prev_sum = sum;
      occ = occ + int'(acc) - int'(oxf);
      if (acc) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got); end
    checks++; if (saw_drop !== 1'b1) begin errors++; $display("FAIL bp_ready_drop: got %b want 1", saw_drop); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1; in0 = 20'h00010; in1 = 20'h00001;
    @(negedge clk);
    in0 = 20'h00020;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_out_valid_rst: got %b want 0", out_valid); end
    checks++; if (sum !== 20'h0) begin errors++; $display("FAIL rmf_sum_rst: got %h want 00000", sum); end
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in0 = 20'h00100; in1 = 20'h00023;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmf_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_no_emit: got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmf_new_valid: got %b want 1", out_valid); end
    checks++; if (sum !== 20'h00123) begin errors++; $display("FAIL rmf_new_sum: got %h want 00123", sum); end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add_overflow();
    test_arithmetic();
    test_saturate();
    @(negedge clk);
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
